usreg_seq_ctrl: RTL and testbench

//   Command sequencer for the universal shift register (usreg, sel 00 hold / 01 shift right / 10 shift left / 11 load).

---
 rtl/usreg_pkg.sv | 23 ++
 rtl/usreg.sv | 29 ++
 rtl/usreg_seq_ctrl.sv | 123 ++++++++++++
 tb/tb_usreg_seq_ctrl.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/usreg_pkg.sv
// rtl/usreg_pkg.sv - shared encodings for the universal shift register and its sequencer
package usreg_pkg;

  // usreg mode select
  localparam logic [1:0] SEL_HOLD = 2'b00;
  localparam logic [1:0] SEL_SHR  = 2'b01;
  localparam logic [1:0] SEL_SHL  = 2'b10;
  localparam logic [1:0] SEL_LOAD = 2'b11;

  // sequencer command opcodes
  localparam logic [1:0] OP_TX   = 2'b00;
  localparam logic [1:0] OP_RX   = 2'b01;
  localparam logic [1:0] OP_ROTL = 2'b10;
  localparam logic [1:0] OP_LOAD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_LOAD  = 2'b01,
    ST_SHIFT = 2'b10,
    ST_DONE  = 2'b11
  } seq_state_t;

endpackage

// File: rtl/usreg.sv
// rtl/usreg.sv - universal shift register: hold, shift right, shift left, parallel load
module usreg
  import usreg_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       sel,
  input  logic [WIDTH-1:0] data_in,
  input  logic             serial_in,
  output logic [WIDTH-1:0] data_out
);

  // register update selected by sel; right shift enters at the MSB, left shift at the LSB
  always_ff @(posedge clk) begin
    if (rst) begin
      data_out <= '0;
    end else begin
      case (sel)
        SEL_SHR:  data_out <= {serial_in, data_out[WIDTH-1:1]};
        SEL_SHL:  data_out <= {data_out[WIDTH-2:0], serial_in};
        SEL_LOAD: data_out <= data_in;
        default:  data_out <= data_out;
      endcase
    end
  end

endmodule

// File: rtl/usreg_seq_ctrl.sv
// rtl/usreg_seq_ctrl.sv - command sequencer driving a usreg for TX, RX, rotate-left and load
module usreg_seq_ctrl
  import usreg_pkg::*;
#(
  parameter  int WIDTH = 4,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [CNT_W-1:0] cmd_len,
  input  logic             ser_in,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [1:0]       usr_sel,
  output logic [WIDTH-1:0] usr_data_in,
  output logic             usr_serial_in,
  input  logic [WIDTH-1:0] usr_data_out
);

  localparam logic [CNT_W-1:0] LEN_MAX = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] LEN_ONE = CNT_W'(1);

  seq_state_t       state;
  logic [1:0]       op_q;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] result_q;
  logic [1:0]       sel_q;
  logic [WIDTH-1:0] din_q;
  logic             done_q;
  logic [CNT_W-1:0] len_clamped;
  logic             shifting;

  assign len_clamped = (cmd_len > LEN_MAX) ? LEN_MAX : cmd_len;
  assign shifting    = (state == ST_SHIFT);

  // sequencer FSM; usr_sel, usr_data_in and done are registered alongside the state they belong to
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      op_q     <= OP_TX;
      cnt      <= '0;
      result_q <= '0;
      sel_q    <= SEL_HOLD;
      din_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            op_q <= cmd_op;
            cnt  <= len_clamped;
            if (cmd_op == OP_RX) begin
              // receive needs no preload; a zero-length receive completes immediately
              if (len_clamped == '0) begin
                state  <= ST_DONE;
                done_q <= 1'b1;
              end else begin
                state <= ST_SHIFT;
                sel_q <= SEL_SHR;
              end
            end else begin
              state <= ST_LOAD;
              sel_q <= SEL_LOAD;
              din_q <= cmd_data;
            end
          end
        end
        ST_LOAD: begin
          din_q <= '0;
          if (cnt == '0 || op_q == OP_LOAD) begin
            state  <= ST_DONE;
            sel_q  <= SEL_HOLD;
            done_q <= 1'b1;
          end else begin
            state <= ST_SHIFT;
            sel_q <= (op_q == OP_ROTL) ? SEL_SHL : SEL_SHR;
          end
        end
        ST_SHIFT: begin
          cnt <= cnt - LEN_ONE;
          if (cnt == LEN_ONE) begin
            state  <= ST_DONE;
            sel_q  <= SEL_HOLD;
            done_q <= 1'b1;
          end
        end
        ST_DONE: begin
          result_q <= usr_data_out;
          done_q   <= 1'b0;
          state    <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // serial-side feed into the usreg: zeros for TX, client bit for RX, wrap-around MSB for rotate
  always_comb begin
    usr_serial_in = 1'b0;
    if (shifting) begin
      case (op_q)
        OP_RX:   usr_serial_in = ser_in;
        OP_ROTL: usr_serial_in = usr_data_out[WIDTH-1];
        default: usr_serial_in = 1'b0;
      endcase
    end
  end

  assign cmd_ready   = (state == ST_IDLE) && !rst;
  assign ser_valid   = shifting && (op_q != OP_ROTL);
  assign ser_out     = shifting && (op_q == OP_TX) && usr_data_out[0];
  assign done        = done_q;
  assign result      = (state == ST_DONE) ? usr_data_out : result_q;
  assign usr_sel     = sel_q;
  assign usr_data_in = din_q;

endmodule

// File: tb/tb_usreg_seq_ctrl.sv
// tb/tb_usreg_seq_ctrl.sv - directed vector bench for the usreg sequencer paired with a usreg
module tb_usreg_seq_ctrl;
  import usreg_pkg::*;

  localparam int WIDTH = 4;
  localparam int CNT_W = $clog2(WIDTH + 1);

  logic             clk = 1'b0;
  logic             rst;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [WIDTH-1:0] cmd_data;
  logic [CNT_W-1:0] cmd_len;
  logic             ser_in;
  logic             ser_out;
  logic             ser_valid;
  logic             done;
  logic [WIDTH-1:0] result;
  logic [1:0]       usr_sel;
  logic [WIDTH-1:0] usr_data_in;
  logic             usr_serial_in;
  logic [WIDTH-1:0] usr_data_out;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  usreg_seq_ctrl #(.WIDTH(WIDTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op       (cmd_op),
    .cmd_data     (cmd_data),
    .cmd_len      (cmd_len),
    .ser_in       (ser_in),
    .ser_out      (ser_out),
    .ser_valid    (ser_valid),
    .done         (done),
    .result       (result),
    .usr_sel      (usr_sel),
    .usr_data_in  (usr_data_in),
    .usr_serial_in(usr_serial_in),
    .usr_data_out (usr_data_out)
  );

  usreg #(.WIDTH(WIDTH)) u_reg (
    .clk      (clk),
    .rst      (rst),
    .sel      (usr_sel),
    .data_in  (usr_data_in),
    .serial_in(usr_serial_in),
    .data_out (usr_data_out)
  );

  typedef struct {
    logic [1:0]       op;
    logic [WIDTH-1:0] data;
    logic [CNT_W-1:0] len;
    logic [WIDTH-1:0] rxb;
    logic [WIDTH-1:0] exp_res;
    int               exp_lat;
    logic [WIDTH-1:0] exp_ser;
    int               exp_nser;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Called just after a negedge; returns at the negedge of the done cycle (lat = cycles after accept)
  task automatic run_cmd(input logic [1:0] op, input logic [WIDTH-1:0] data,
                         input logic [CNT_W-1:0] len, input logic [WIDTH-1:0] rxb,
                         output int lat, output logic [WIDTH-1:0] res,
                         output logic [WIDTH-1:0] ser, output int nser);
    int w;
    lat  = -1;
    res  = '0;
    ser  = '0;
    nser = 0;
    cmd_op    = op;
    cmd_data  = data;
    cmd_len   = len;
    cmd_valid = 1'b1;
    w = 0;
    while (!cmd_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    @(posedge clk);
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      if (ser_valid) begin
        if (nser < WIDTH) begin
          ser[nser] = ser_out;
          ser_in    = rxb[nser];
        end
        nser++;
      end
      if (done) begin
        lat = k;
        res = result;
        break;
      end
    end
    ser_in = 1'b0;
  endtask

  initial begin
    int               lat;
    int               nser;
    int               k;
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] ser;
    logic             busy_ok;

    vecs[0] = '{OP_TX,   4'b1010, 3'd4, 4'b0000, 4'b0000, 6, 4'b1010, 4};
    vecs[1] = '{OP_RX,   4'b0000, 3'd4, 4'b1101, 4'b1101, 5, 4'b0000, 4};
    vecs[2] = '{OP_ROTL, 4'b1001, 3'd1, 4'b0000, 4'b0011, 3, 4'b0000, 0};
    vecs[3] = '{OP_ROTL, 4'b1001, 3'd3, 4'b0000, 4'b1100, 5, 4'b0000, 0};
    vecs[4] = '{OP_ROTL, 4'b1001, 3'd7, 4'b0000, 4'b1001, 6, 4'b0000, 0};
    vecs[5] = '{OP_LOAD, 4'b0110, 3'd5, 4'b0000, 4'b0110, 2, 4'b0000, 0};
    vecs[6] = '{OP_TX,   4'b1011, 3'd0, 4'b0000, 4'b1011, 2, 4'b0000, 0};
    vecs[7] = '{OP_RX,   4'b0000, 3'd2, 4'b0011, 4'b1110, 3, 4'b0000, 2};
    vecs[8] = '{OP_TX,   4'b0110, 3'd2, 4'b0000, 4'b0001, 4, 4'b0010, 2};
    vecs[9] = '{OP_RX,   4'b0000, 3'd0, 4'b0000, 4'b0001, 1, 4'b0000, 0};

    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = OP_TX;
    cmd_data  = '0;
    cmd_len   = '0;
    ser_in    = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_cmd_ready", int'(cmd_ready), 0);
    check("rst_done", int'(done), 0);
    check("rst_result", int'(result), 0);
    check("rst_usr_sel", int'(usr_sel), 0);
    check("rst_ser_valid", int'(ser_valid), 0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_cmd_ready", int'(cmd_ready), 1);

    for (int i = 0; i < 10; i++) begin
      run_cmd(vecs[i].op, vecs[i].data, vecs[i].len, vecs[i].rxb, lat, res, ser, nser);
      check($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
      check($sformatf("v%0d_result", i), int'(res), int'(vecs[i].exp_res));
      check($sformatf("v%0d_ser_count", i), nser, vecs[i].exp_nser);
      check($sformatf("v%0d_ser_bits", i), int'(ser), int'(vecs[i].exp_ser));
      @(negedge clk);
      check($sformatf("v%0d_done_pulse", i), int'(done), 0);
      check($sformatf("v%0d_ready_after", i), int'(cmd_ready), 1);
      check($sformatf("v%0d_result_held", i), int'(result), int'(vecs[i].exp_res));
    end

    // second command presented while a TX is busy: must wait, then run intact
    cmd_op    = OP_TX;
    cmd_data  = 4'b1010;
    cmd_len   = 3'd4;
    cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_op   = OP_ROTL;
    cmd_data = 4'b1001;
    cmd_len  = 3'd3;
    k = 1;
    busy_ok = 1'b1;
    while (!done && k < 20) begin
      if (cmd_ready) busy_ok = 1'b0;
      @(negedge clk);
      k++;
    end
    check("hold_busy_ready_low", int'(busy_ok), 1);
    check("hold_tx_latency", k, 6);
    check("hold_ready_in_done", int'(cmd_ready), 0);
    check("hold_tx_result", int'(result), 0);
    @(negedge clk);
    check("hold_ready_after_done", int'(cmd_ready), 1);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    k = 1;
    while (!done && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("hold_rotl_latency", k, 5);
    check("hold_rotl_result", int'(result), int'(4'b1100));

    // reset asserted during the second SHIFT cycle of a TX
    @(negedge clk);
    cmd_op    = OP_TX;
    cmd_data  = 4'b1010;
    cmd_len   = 3'd4;
    cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("mid_ser_valid_before_rst", int'(ser_valid), 1);
    rst = 1'b1;
    @(negedge clk);
    check("mrst_done", int'(done), 0);
    check("mrst_result", int'(result), 0);
    check("mrst_usr_sel", int'(usr_sel), 0);
    check("mrst_ser_valid", int'(ser_valid), 0);
    check("mrst_cmd_ready", int'(cmd_ready), 0);
    rst = 1'b0;
    @(negedge clk);
    check("mrst_ready_after", int'(cmd_ready), 1);
    run_cmd(OP_LOAD, 4'b0101, 3'd0, 4'b0000, lat, res, ser, nser);
    check("mrst_load_latency", lat, 2);
    check("mrst_load_result", int'(res), int'(4'b0101));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
